counter_sweep_ctrl: RTL

COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

---
 rtl/counter_sweep_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/counter_sweep_ctrl.sv
// Sweep controller for an external 4-bit up/down counter: loads lo, ramps to hi and
// back to lo, repeating n_sweeps times, with abort, error and done reporting.
module counter_sweep_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] lo,
    input  logic [3:0] hi,
    input  logic [3:0] n_sweeps,
    input  logic [3:0] cnt_q,
    output logic       cnt_en,
    output logic       cnt_up,
    output logic       cnt_load,
    output logic [3:0] cnt_load_val,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] sweep_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] lo_q, lo_d;
    logic [3:0] hi_q, hi_d;
    logic [3:0] n_q, n_d;
    logic [3:0] sweep_idx_q, sweep_idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       active;

    assign active = (state_q == S_LOAD) || (state_q == S_UP) || (state_q == S_DOWN);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // one unassigned; a missing default here would infer a latch.
        state_d      = state_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        n_d          = n_q;
        sweep_idx_d  = sweep_idx_q;
        err_d        = 1'b0;
        cnt_en       = 1'b0;
        cnt_up       = 1'b1;
        cnt_load     = 1'b0;
        cnt_load_val = 4'd0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((lo < hi) && (n_sweeps != 4'd0)) begin
                        lo_d        = lo;
                        hi_d        = hi;
                        n_d         = n_sweeps;
                        sweep_idx_d = 4'd0;
                        state_d     = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                cnt_load     = 1'b1;
                cnt_load_val = lo_q;
                state_d      = S_UP;
            end
            S_UP: begin
                if (cnt_q != hi_q) begin
                    cnt_en = 1'b1;
                end else begin
                    state_d = S_DOWN;
                end
            end
            S_DOWN: begin
                cnt_up = 1'b0;
                if (cnt_q != lo_q) begin
                    cnt_en = 1'b1;
                end else begin
                    sweep_idx_d = sweep_idx_q + 4'd1;
                    state_d     = (sweep_idx_q + 4'd1 == n_q) ? S_DONE : S_UP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides whatever the active state decided, including the load strobe.
        if (abort && active) begin
            state_d     = S_IDLE;
            cnt_en      = 1'b0;
            cnt_load    = 1'b0;
            sweep_idx_d = sweep_idx_q;
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_UP) || (state_d == S_DOWN);
        done_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lo_q        <= 4'd0;
            hi_q        <= 4'd0;
            n_q         <= 4'd0;
            sweep_idx_q <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            n_q         <= n_d;
            sweep_idx_q <= sweep_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign sweep_idx = sweep_idx_q;

endmodule
